// File: rtl/maxpool_streamer.sv
// Captures an N x N map of unsigned DW-bit values and streams (N/P)^2 pooled maxima,
// one P x P window at a time, over a valid/ready output.
module maxpool_streamer #(
  parameter int DW = 6,
  parameter int N  = 6,
  parameter int P  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*N*DW-1:0] map_in,
  input  logic              map_valid,
  output logic              map_ready,
  output logic [DW-1:0]     out_data,
  output logic [3:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int NW   = N / P;
  localparam int NWIN = NW * NW;
  localparam int WW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int EW   = (P > 1) ? $clog2(P) : 1;
  localparam int RW   = (N > 1) ? $clog2(N) : 1;

  generate
    if (N % P != 0) begin : g_bad_geometry
      $error("maxpool_streamer: N must be a multiple of P");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, POOL, EMIT} state_t;

  state_t          state_q;
  logic [DW-1:0]   buf_q [N][N];
  logic [DW-1:0]   max_q;
  logic [WW-1:0]   wr_q, wc_q;
  logic [EW-1:0]   er_q, ec_q;
  logic [3:0]      win_q;
  logic [DW-1:0]   out_data_q;
  logic [3:0]      out_idx_q;
  logic            out_valid_q, out_last_q, map_ready_q, busy_q;

  logic [RW-1:0]   row, col;
  logic [DW-1:0]   elem, pooled_d;
  logic            first_elem, last_elem;

  function automatic logic [DW-1:0] max_u(input logic [DW-1:0] run, input logic [DW-1:0] cand);
    return (cand > run) ? cand : run;
  endfunction

  always_comb begin
    row        = RW'(P * 32'(wr_q) + 32'(er_q));
    col        = RW'(P * 32'(wc_q) + 32'(ec_q));
    elem       = buf_q[row][col];
    first_elem = (er_q == '0) && (ec_q == '0);
    last_elem  = (er_q == EW'(P - 1)) && (ec_q == EW'(P - 1));
    pooled_d   = first_elem ? elem : max_u(max_q, elem);
  end

  // Datapath: map buffer and running maximum carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && map_valid) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          buf_q[r][c] <= map_in[(r*N+c)*DW +: DW];
        end
      end
    end
    if (state_q == POOL) max_q <= pooled_d;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      wc_q        <= '0;
      er_q        <= '0;
      ec_q        <= '0;
      win_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      map_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (map_valid) begin
            state_q     <= POOL;
            wr_q        <= '0;
            wc_q        <= '0;
            er_q        <= '0;
            ec_q        <= '0;
            win_q       <= '0;
            map_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        POOL: begin
          if (last_elem) begin
            er_q        <= '0;
            ec_q        <= '0;
            out_data_q  <= pooled_d;
            out_idx_q   <= win_q;
            out_last_q  <= (win_q == 4'(NWIN - 1));
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else if (ec_q == EW'(P - 1)) begin
            ec_q <= '0;
            er_q <= er_q + 1'b1;
          end else begin
            ec_q <= ec_q + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q     <= IDLE;
              map_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              win_q   <= win_q + 1'b1;
              state_q <= POOL;
              if (wc_q == WW'(NW - 1)) begin
                wc_q <= '0;
                wr_q <= wr_q + 1'b1;
              end else begin
                wc_q <= wc_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign map_ready = map_ready_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_streamer.sv
// Scoreboard bench for maxpool_streamer: a loop-based pooling model fills an expectation
// queue per map, and a negedge monitor checks every output handshake against it.
module tb_maxpool_streamer;

  localparam int DW = 6, N = 6, P = 2, NW = N / P, NWIN = NW * NW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*N*DW-1:0] map_in;
  logic              map_valid, map_ready;
  logic [DW-1:0]     out_data;
  logic [3:0]        out_idx;
  logic              out_valid, out_ready, out_last, busy;

  maxpool_streamer #(.DW(DW), .N(N), .P(P)) dut (
    .clk(clk), .rst(rst), .map_in(map_in), .map_valid(map_valid), .map_ready(map_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int idx; int last;} exp_t;
  exp_t expq[$];
  int   cur [N][N];
  int   vectors = 0, miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fill_map(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0: cur[r][c] = 0;
          1: cur[r][c] = r * N + c;
          2: cur[r][c] = (r % P == 0 && c % P == 0) ? 63 : 1;
          3: cur[r][c] = int'($urandom_range(0, 63));
          default: cur[r][c] = int'($urandom_range(0, 3));
        endcase
  endtask

  function automatic logic [N*N*DW-1:0] pack_map();
    logic [N*N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N+c)*DW +: DW] = DW'(cur[r][c]);
    return v;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int wr = 0; wr < NW; wr++)
      for (int wc = 0; wc < NW; wc++) begin
        e.data = 0;
        for (int dr = 0; dr < P; dr++)
          for (int dc = 0; dc < P; dc++)
            if (cur[P*wr+dr][P*wc+dc] > e.data) e.data = cur[P*wr+dr][P*wc+dc];
        e.idx  = wr * NW + wc;
        e.last = (e.idx == NWIN - 1) ? 1 : 0;
        expq.push_back(e);
      end
  endtask

  // Monitor: hold-stability under backpressure and in-order scoreboard on each handshake.
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [3:0]    pi = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(pd));
        check("hold_idx", int'(out_idx), int'(pi));
        check("hold_last", int'(out_last), int'(pl));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: idx %0d data %0d with nothing expected", out_idx, out_data);
        end else begin
          e = expq.pop_front();
          check("out_data", int'(out_data), e.data);
          check("out_idx", int'(out_idx), e.idx);
          check("out_last", int'(out_last), e.last);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
    end
  end

  // mode: 0 plain, 1 foreign map pulsed while busy, 2 random out_ready,
  //       3 ten-cycle stall on idx 3, 4 reset while idx 3 is pending.
  task automatic run_map(input int kind, input int mode);
    int n, first, bp_left, wt;
    logic [N*N*DW-1:0] packed_map;
    fill_map(kind);
    packed_map = pack_map();
    @(posedge clk); #1;
    map_in = packed_map;
    map_valid = 1'b1;
    wt = 0;
    while (!map_ready && wt < 200) begin @(posedge clk); #1; wt++; end
    if (!map_ready) begin
      vectors++; miscompares++;
      $display("FAIL map_ready_timeout: map_ready still 0 after %0d cycles", wt);
      return;
    end
    push_expected();
    @(posedge clk); #1;
    map_valid = 1'b0;
    check("busy_after_capture", int'(busy), 1);
    check("map_ready_after_capture", int'(map_ready), 0);
    n = 0; first = -1; bp_left = 0;
    while (!map_ready && n < 400) begin
      map_valid = 1'b0;
      if (mode == 1 && n == 6) begin
        map_in = ~packed_map;
        map_valid = 1'b1;
      end
      if (mode == 2) out_ready = ($urandom_range(0, 2) != 0);
      if (mode == 3) begin
        if (bp_left > 0) begin
          bp_left--;
          if (bp_left == 0) out_ready = 1'b1;
        end else if (out_valid && out_idx == 4'd3 && out_ready) begin
          out_ready = 1'b0;
          bp_left = 10;
        end
      end
      if (mode == 4 && out_valid && out_idx == 4'd3) begin
        out_ready = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_map_ready", int'(map_ready), 1);
        @(negedge clk); #2;
        rst = 1'b0;
        expq.delete();
        out_ready = 1'b1;
        return;
      end
      @(posedge clk); #1;
      n++;
      if (out_valid && first < 0) first = n;
    end
    map_valid = 1'b0;
    out_ready = 1'b1;
    if (!map_ready) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: map still busy after %0d cycles", n);
    end else if (mode == 0 || mode == 1) begin
      check("first_valid_latency", first, 4);
      check("map_done_cycles", n, 45);
      check("busy_when_done", int'(busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; map_valid = 1'b0; out_ready = 1'b1; map_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_idx", int'(out_idx), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_map_ready", int'(map_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    run_map(0, 0);
    run_map(1, 0);
    run_map(2, 0);
    run_map(3, 3);
    run_map(3, 1);
    run_map(3, 4);
    run_map(1, 0);
    for (int i = 0; i < 3; i++) run_map(3, 2);
    run_map(4, 0);
    run_map(4, 2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
